ah_ddr2pl_data_distributor: RTL

- Playback counterpart of the PL-to-DDR sample packer.
- Accepts 32-bit words read from DDR over a valid/ready interface and unpacks each word into 32/DATA_WIDTH samples of DATA_WIDTH bits, LSB-first.
- Emits one sample per (oversampling+1) enabled cycles toward PL logic.
- Holds one prefetch word, so a steady sample stream continues across word boundaries without bubbles.

---
 rtl/ah_pl2ddr_pkg.sv | 19 +
 rtl/ah_ddr2pl_word_buffer.sv | 55 +++++
 rtl/ah_ddr2pl_data_distributor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ah_pl2ddr_pkg.sv
// Shared constants and helpers for the PL<->DDR sample packer/distributor pair.
package ah_pl2ddr_pkg;

  localparam int WORD_WIDTH         = 32;
  localparam int SAMPLES_LEFT_WIDTH = 7;
  localparam int SHIFT_COUNT_WIDTH  = 6;

  // Number of DATA_WIDTH-bit samples carried by one 32-bit DDR word.
  function automatic int samples_per_word(input int dataWidth);
    return WORD_WIDTH / dataWidth;
  endfunction

  // Only power-of-two widths that divide the word evenly are supported.
  function automatic bit data_width_is_legal(input int dataWidth);
    return (dataWidth == 1) || (dataWidth == 2) || (dataWidth == 4) ||
           (dataWidth == 8) || (dataWidth == 16) || (dataWidth == 32);
  endfunction

endpackage

// File: rtl/ah_ddr2pl_word_buffer.sv
// One-entry prefetch buffer between the DDR reader and the sample shift register.
// It can accept a new word in the same cycle its current word is unloaded.
module ah_ddr2pl_word_buffer
  import ah_pl2ddr_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  unload_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  full_o
);

  logic [WORD_WIDTH-1:0] bufWord_q, bufWord_d;
  logic                  bufFull_q, bufFull_d;
  logic                  accept;

  // Ready whenever the slot is free or is being emptied this cycle; never during flush or reset.
  always_comb begin
    word_ready_o = rstn_i && !flush_i && (!bufFull_q || unload_i);
    accept       = word_valid_i && word_ready_o;
  end

  // Next-state: flush wins, then a new word, then a plain unload.
  always_comb begin
    bufWord_d = bufWord_q;
    bufFull_d = bufFull_q;
    if (flush_i) begin
      bufFull_d = 1'b0;
    end else if (accept) begin
      bufWord_d = word_i;
      bufFull_d = 1'b1;
    end else if (unload_i) begin
      bufFull_d = 1'b0;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bufWord_q <= '0;
      bufFull_q <= 1'b0;
    end else begin
      bufWord_q <= bufWord_d;
      bufFull_q <= bufFull_d;
    end
  end

  assign word_o = bufWord_q;
  assign full_o = bufFull_q;

endmodule

// File: rtl/ah_ddr2pl_data_distributor.sv
// Unpacks 32-bit DDR words into DATA_WIDTH-bit samples, LSB-first, and paces them
// out at one sample per (oversampling+1) enabled cycles. A prefetch word keeps the
// stream gap-free across word boundaries.
module ah_ddr2pl_data_distributor
  import ah_pl2ddr_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  input  logic [31:0]                   word_in_i,
  input  logic                          word_valid_i,
  output logic                          word_ready_o,
  input  logic                          data_en_i,
  input  logic [31:0]                   oversampling_i,
  output logic [DATA_WIDTH-1:0]         data_out_o,
  output logic                          data_valid_o,
  output logic [31:0]                   data_index_o,
  output logic [SAMPLES_LEFT_WIDTH-1:0] samples_left_o,
  output logic                          underrun_o
);

  localparam int SPW = samples_per_word(DATA_WIDTH);
  localparam logic [SHIFT_COUNT_WIDTH-1:0]  SPW_CNT  = SHIFT_COUNT_WIDTH'(SPW);
  localparam logic [SAMPLES_LEFT_WIDTH-1:0] SPW_LEFT = SAMPLES_LEFT_WIDTH'(SPW);

  if (!data_width_is_legal(DATA_WIDTH)) begin : gen_bad_width
    $error("ah_ddr2pl_data_distributor: DATA_WIDTH must be 1, 2, 4, 8, 16 or 32");
  end

  logic [WORD_WIDTH-1:0]        shiftReg_q, shiftReg_d;
  logic [SHIFT_COUNT_WIDTH-1:0] shiftCnt_q, shiftCnt_d;
  logic [31:0]                  osCnt_q, osCnt_d;
  logic [DATA_WIDTH-1:0]        dataOut_q, dataOut_d;
  logic                         dataValid_q, dataValid_d;
  logic [31:0]                  dataIndex_q, dataIndex_d;
  logic                         underrun_q, underrun_d;

  logic                  tick;
  logic                  shEmpty;
  logic                  shLast;
  logic                  bufUnload;
  logic                  bufFull;
  logic [WORD_WIDTH-1:0] bufWord;

  // Sample pacing and refill decision; >= keeps the counter safe when oversampling drops.
  always_comb begin
    tick      = data_en_i && (osCnt_q >= oversampling_i);
    shEmpty   = (shiftCnt_q == '0);
    shLast    = (shiftCnt_q == SHIFT_COUNT_WIDTH'(1));
    bufUnload = bufFull && !flush_i && (shEmpty || (tick && shLast));
  end

  ah_ddr2pl_word_buffer u_word_buffer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (flush_i),
    .unload_i     (bufUnload),
    .word_i       (word_in_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .word_o       (bufWord),
    .full_o       (bufFull)
  );

  // Emission, underrun detection and shift-register reload; flush overrides all of it.
  always_comb begin
    shiftReg_d  = shiftReg_q;
    shiftCnt_d  = shiftCnt_q;
    osCnt_d     = osCnt_q;
    dataOut_d   = dataOut_q;
    dataValid_d = 1'b0;
    dataIndex_d = dataIndex_q;
    underrun_d  = underrun_q;
    if (flush_i) begin
      shiftCnt_d = '0;
      osCnt_d    = '0;
      underrun_d = 1'b0;
    end else begin
      if (tick) begin
        if (!shEmpty) begin
          dataOut_d   = shiftReg_q[DATA_WIDTH-1:0];
          dataValid_d = 1'b1;
          shiftReg_d  = shiftReg_q >> DATA_WIDTH;
          shiftCnt_d  = shiftCnt_q - SHIFT_COUNT_WIDTH'(1);
          dataIndex_d = dataIndex_q + 32'd1;
          osCnt_d     = '0;
        end else begin
          underrun_d = 1'b1;
        end
      end else if (data_en_i) begin
        osCnt_d = osCnt_q + 32'd1;
      end
      if (bufUnload) begin
        shiftReg_d = bufWord;
        shiftCnt_d = SPW_CNT;
      end
    end
  end

  // Datapath state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shiftReg_q  <= '0;
      shiftCnt_q  <= '0;
      osCnt_q     <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      dataIndex_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      shiftReg_q  <= shiftReg_d;
      shiftCnt_q  <= shiftCnt_d;
      osCnt_q     <= osCnt_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      dataIndex_q <= dataIndex_d;
      underrun_q  <= underrun_d;
    end
  end

  assign data_out_o     = dataOut_q;
  assign data_valid_o   = dataValid_q;
  assign data_index_o   = dataIndex_q;
  assign underrun_o     = underrun_q;
  assign samples_left_o = {1'b0, shiftCnt_q} + (bufFull ? SPW_LEFT : '0);

endmodule
